// File: rtl/mem_bus_scheduler_if.sv
// Request/response and memory-bus signal bundle for mem_bus_scheduler.
// The slave modport is the scheduler. The master modport is the CPU plus memory side.
interface mem_bus_scheduler_if;
   logic [31:0] instr_address_in;
   logic        instr_read_in;
   logic [31:0] instr_read_value_out;
   logic        instr_ready;
   logic [31:0] data_address_in;
   logic        data_read_in;
   logic        data_write_in;
   logic [3:0]  data_write_mask_in;
   logic [31:0] data_write_value_in;
   logic [31:0] data_read_value_out;
   logic        data_ready;
   logic [31:0] address_out;
   logic        read_out;
   logic        write_out;
   logic [3:0]  write_mask_out;
   logic [31:0] write_value_out;
   logic [31:0] read_value_in;
   logic        mem_ready_in;
   logic        bus_error_out;

   modport slave (
      input  instr_address_in, instr_read_in,
      input  data_address_in, data_read_in, data_write_in,
      input  data_write_mask_in, data_write_value_in,
      input  read_value_in, mem_ready_in,
      output instr_read_value_out, instr_ready,
      output data_read_value_out, data_ready,
      output address_out, read_out, write_out, write_mask_out, write_value_out,
      output bus_error_out
   );

   modport master (
      output instr_address_in, instr_read_in,
      output data_address_in, data_read_in, data_write_in,
      output data_write_mask_in, data_write_value_in,
      output read_value_in, mem_ready_in,
      input  instr_read_value_out, instr_ready,
      input  data_read_value_out, data_ready,
      input  address_out, read_out, write_out, write_mask_out, write_value_out,
      input  bus_error_out
   );
endinterface

// File: rtl/mem_bus_scheduler.sv
// Shares one multi-cycle memory bus between instruction fetch and load/store. Data has priority, with a starvation guard for fetch.
// Define BUS_TIMEOUT_EN to abort a grant after TIMEOUT_CYCLES cycles without mem_ready_in.
module mem_bus_scheduler #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic           clk,
   input logic           reset,
   mem_bus_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  starve_reg, starve_next;
   logic [31:0] address_reg, address_next;
   logic        read_reg, read_next;
   logic        write_reg, write_next;
   logic [3:0]  mask_reg, mask_next;
   logic [31:0] value_reg, value_next;

   logic        granted;
   logic        timeout;
   logic        done;
   logic        data_req;
   logic        fetch_forced;
   logic [31:0] resp_value;

   assign granted = (state_reg != IDLE);

`ifdef BUS_TIMEOUT_EN
   localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [WAIT_W-1:0] wait_reg, wait_next;

   // Fires in the grant cycle that would bring the wait count to TIMEOUT_CYCLES.
   assign timeout = granted && !bus.mem_ready_in &&
                    (wait_reg == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wait_next = wait_reg;
      if (!granted)
         wait_next = '0;
      else if (!bus.mem_ready_in)
         wait_next = wait_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         wait_reg <= '0;
      else
         wait_reg <= wait_next;
   end
`else
   assign timeout = 1'b0;
`endif

   // Ready is suppressed while reset is asserted so an aborted grant never completes.
   assign done       = granted && !reset && (bus.mem_ready_in || timeout);
   assign resp_value = timeout ? 32'hFFFF_FFFF : bus.read_value_in;

   assign bus.instr_ready          = done && (state_reg == GRANT_I);
   assign bus.data_ready           = done && (state_reg == GRANT_D);
   assign bus.instr_read_value_out = bus.instr_ready ? resp_value : 32'h0;
   assign bus.data_read_value_out  = bus.data_ready ? resp_value : 32'h0;
   assign bus.bus_error_out        = done && timeout;

   assign bus.address_out     = address_reg;
   assign bus.read_out        = read_reg;
   assign bus.write_out       = write_reg;
   assign bus.write_mask_out  = mask_reg;
   assign bus.write_value_out = value_reg;

   assign data_req     = bus.data_read_in || bus.data_write_in;
   assign fetch_forced = bus.instr_read_in && (starve_reg == 4'(STARVE_LIMIT));

   always_comb begin
      state_next   = state_reg;
      starve_next  = starve_reg;
      address_next = address_reg;
      read_next    = read_reg;
      write_next   = write_reg;
      mask_next    = mask_reg;
      value_next   = value_reg;
      case (state_reg)
         IDLE: begin
            if (data_req && !fetch_forced) begin
               state_next   = GRANT_D;
               address_next = bus.data_address_in;
               read_next    = bus.data_read_in && !bus.data_write_in;
               write_next   = bus.data_write_in;
               mask_next    = bus.data_write_mask_in;
               value_next   = bus.data_write_value_in;
               if (!bus.instr_read_in)
                  starve_next = 4'd0;
               else if (starve_reg != 4'(STARVE_LIMIT))
                  starve_next = starve_reg + 4'd1;
            end else if (bus.instr_read_in) begin
               state_next   = GRANT_I;
               address_next = bus.instr_address_in;
               read_next    = 1'b1;
               write_next   = 1'b0;
               mask_next    = 4'h0;
               value_next   = 32'h0;
               starve_next  = 4'd0;
            end
         end
         GRANT_I, GRANT_D: begin
            if (bus.mem_ready_in || timeout) begin
               state_next = IDLE;
               read_next  = 1'b0;
               write_next = 1'b0;
               mask_next  = 4'h0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         starve_reg  <= 4'd0;
         address_reg <= 32'h0;
         read_reg    <= 1'b0;
         write_reg   <= 1'b0;
         mask_reg    <= 4'h0;
         value_reg   <= 32'h0;
      end else begin
         state_reg   <= state_next;
         starve_reg  <= starve_next;
         address_reg <= address_next;
         read_reg    <= read_next;
         write_reg   <= write_next;
         mask_reg    <= mask_next;
         value_reg   <= value_next;
      end
   end
endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Self-checking bench for mem_bus_scheduler. It uses a transaction-level model of ownership, starvation and bus capture.
// The timeout scenario is exercised only when BUS_TIMEOUT_EN is defined.
module tb_mem_bus_scheduler;
   localparam int LIMIT   = 4;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_bus_scheduler_if bus ();

   mem_bus_scheduler #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Outstanding requests held by each requester, plus the model's starvation count.
   logic        pi, pd, pd_rd, pd_wr;
   logic [31:0] pi_addr, pd_addr, pd_val;
   logic [3:0]  pd_mask;
   int          m_starve;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_reqs();
      bus.instr_read_in       = pi;
      bus.instr_address_in    = pi_addr;
      bus.data_read_in        = pd & pd_rd;
      bus.data_write_in       = pd & pd_wr;
      bus.data_address_in     = pd_addr;
      bus.data_write_mask_in  = pd_mask;
      bus.data_write_value_in = pd_val;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_irdy"}, 32'(bus.instr_ready), 32'h0);
      chk({tag, "_drdy"}, 32'(bus.data_ready), 32'h0);
      chk({tag, "_rd"}, 32'(bus.read_out), 32'h0);
      chk({tag, "_wr"}, 32'(bus.write_out), 32'h0);
      chk({tag, "_mask"}, 32'(bus.write_mask_out), 32'h0);
   endtask

   task automatic raise_data(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [3:0] m, input logic [31:0] v);
      pd = 1'b1; pd_rd = rd; pd_wr = wr; pd_addr = a; pd_mask = m; pd_val = v;
   endtask

   // Entered at posedge+1 of an IDLE cycle. It returns at posedge+1 of the IDLE cycle after completion.
   task automatic do_txn(input string tag, input int waits, input logic [31:0] rv);
      logic        own_d;
      logic [31:0] e_addr, e_val;
      logic        e_rd, e_wr;
      logic [3:0]  e_mask;
      drive_reqs();
      own_d = pd && !(m_starve == LIMIT && pi);
      if (own_d) begin
         e_addr = pd_addr; e_rd = pd_rd && !pd_wr; e_wr = pd_wr;
         e_mask = pd_mask; e_val = pd_val;
         m_starve = pi ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else begin
         e_addr = pi_addr; e_rd = 1'b1; e_wr = 1'b0; e_mask = 4'h0; e_val = 32'h0;
         m_starve = 0;
      end
      #4;
      chk_idle({tag, "_idle"});
      tick();
      if (own_d) begin
         bus.data_address_in     = $urandom;
         bus.data_write_value_in = $urandom;
         bus.data_write_mask_in  = 4'($urandom);
      end else begin
         bus.instr_address_in = $urandom;
      end
      for (int c = 0; c <= waits; c++) begin
         bus.mem_ready_in  = (c == waits);
         bus.read_value_in = (c == waits) ? rv : $urandom;
         #4;
         chk({tag, "_addr"}, bus.address_out, e_addr);
         chk({tag, "_rd"}, 32'(bus.read_out), 32'(e_rd));
         chk({tag, "_wr"}, 32'(bus.write_out), 32'(e_wr));
         chk({tag, "_mask"}, 32'(bus.write_mask_out), 32'(e_mask));
         if (own_d) chk({tag, "_wval"}, bus.write_value_out, e_val);
         chk({tag, "_irdy"}, 32'(bus.instr_ready), 32'(!own_d && c == waits));
         chk({tag, "_drdy"}, 32'(bus.data_ready), 32'(own_d && c == waits));
         chk({tag, "_ival"}, bus.instr_read_value_out, (!own_d && c == waits) ? rv : 32'h0);
         chk({tag, "_dval"}, bus.data_read_value_out, (own_d && c == waits) ? rv : 32'h0);
         chk({tag, "_err"}, 32'(bus.bus_error_out), 32'h0);
         tick();
      end
      bus.mem_ready_in = 1'b0;
      if (own_d) pd = 1'b0; else pi = 1'b0;
      drive_reqs();
   endtask

   initial begin
      reset = 1'b1;
      pi = 0; pd = 0; pd_rd = 0; pd_wr = 0;
      pi_addr = 0; pd_addr = 0; pd_val = 0; pd_mask = 0;
      m_starve = 0;
      drive_reqs();
      bus.read_value_in = 32'h0;
      bus.mem_ready_in  = 1'b0;
      repeat (3) tick();
      #4;
      chk_idle("reset");
      chk("reset_addr", bus.address_out, 32'h0);
      chk("reset_err", 32'(bus.bus_error_out), 32'h0);
      reset = 1'b0;
      tick();

      // Single fetch with one-cycle memory latency.
      pi = 1'b1; pi_addr = 32'h100;
      do_txn("fetch1", 0, 32'h13);

      // Simultaneous fetch and store: the store goes first, then the fetch.
      pi = 1'b1; pi_addr = 32'h400;
      raise_data(1'b0, 1'b1, 32'h2000, 4'b0011, 32'hAABB);
      do_txn("both_d", 0, 32'h0);
      do_txn("both_i", 0, 32'h55);

      // Fetch held while data requests arrive back-to-back; the fifth grant goes to fetch.
      for (int k = 0; k < 7; k++) begin
         if (!pi) begin pi = 1'b1; pi_addr = $urandom; end
         if (!pd) raise_data(1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom);
         if (!pd_rd && !pd_wr) pd_rd = 1'b1;
         do_txn("starve", 0, $urandom);
      end
      while (pi || pd) do_txn("drain", 0, $urandom);

      // Store with a slow memory.
      raise_data(1'b0, 1'b1, 32'h3000, 4'hF, 32'hDEAD_BEEF);
      do_txn("slow_st", 3, 32'h0);

      // Read and write together: the write wins.
      raise_data(1'b1, 1'b1, 32'h3004, 4'h5, 32'h1234);
      do_txn("rw_both", 1, 32'h0);

      // Reset in the middle of a data grant.
      raise_data(1'b0, 1'b1, 32'h5000, 4'hC, 32'h77);
      drive_reqs();
      tick();
      tick();
      bus.mem_ready_in = 1'b1;
      reset = 1'b1;
      #4;
      chk("rst_mid_drdy", 32'(bus.data_ready), 32'h0);
      chk("rst_mid_dval", bus.data_read_value_out, 32'h0);
      tick();
      #4;
      chk_idle("rst_mid_after");
      reset = 1'b0;
      bus.mem_ready_in = 1'b0;
      pd = 1'b0; pi = 1'b0; m_starve = 0;
      drive_reqs();
      tick();

      // Randomized mixed traffic.
      for (int n = 0; n < 40; n++) begin
         if (!pi && ($urandom % 2) == 0) begin pi = 1'b1; pi_addr = $urandom; end
         if (!pd && ($urandom % 3) != 0)
            raise_data(1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom);
         if (!pi && !pd) raise_data(1'b1, 1'b0, $urandom, 4'h0, $urandom);
         if (pd && !pd_rd && !pd_wr) pd_rd = 1'b1;
         do_txn("rand", $urandom % 3, $urandom);
      end
      while (pi || pd) do_txn("drain2", 0, $urandom);

`ifdef BUS_TIMEOUT_EN
      // Load with no memory response: abort after TIMEOUT grant cycles.
      raise_data(1'b1, 1'b0, 32'h6000, 4'h0, 32'h0);
      drive_reqs();
      tick();
      for (int c = 1; c <= TIMEOUT; c++) begin
         bus.mem_ready_in = 1'b0;
         #4;
         if (c == TIMEOUT || c == 1 || c == TIMEOUT - 1) begin
            chk("to_drdy", 32'(bus.data_ready), 32'(c == TIMEOUT));
            chk("to_err", 32'(bus.bus_error_out), 32'(c == TIMEOUT));
            chk("to_dval", bus.data_read_value_out, (c == TIMEOUT) ? 32'hFFFF_FFFF : 32'h0);
         end
         tick();
      end
      pd = 1'b0;
      m_starve = 0;
      drive_reqs();
      #4;
      chk_idle("to_after");
      tick();
`endif

      #4;
      chk_idle("final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
